// File: rtl/josh_pkg.sv
// Shared types and constants for the jump-game frame sequencer.
// State encoding, screen bounds, colours and the on-screen test.
package josh_pkg;

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_MENU_WAIT = 3'd1,
    S_DRAW      = 3'd2,
    S_WAIT      = 3'd3,
    S_ERASE     = 3'd4,
    S_UPDATE    = 3'd5,
    S_CHECK     = 3'd6,
    S_OVER      = 3'd7
  } state_t;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  localparam logic [2:0] BG   = 3'b000;
  localparam logic [2:0] DUDE = 3'b111;

  // Sums are one bit wider than the coordinates so a sprite
  // hanging off the right/bottom edge never wraps back on-screen.
  function automatic logic on_screen(
    input logic [8:0] x,
    input logic [7:0] y
  );
    return (x < 9'(SCR_W)) && (y < 8'(SCR_H));
  endfunction

  function automatic logic [2:0] pen(input logic erase);
    return erase ? BG : DUDE;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Datapath and VGA plot bundle between sequencer and game datapath.
// master = sequencer side, slave = datapath/VGA side.
interface game_sequencer_if;

  logic [7:0] dude_x;
  logic [6:0] dude_y;
  logic       collide_valid;
  logic       collide;
  logic       startgame;
  logic       upd_en;
  logic       plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic       erase;

  modport master (
    input  dude_x, dude_y, collide_valid, collide,
    output startgame, upd_en, plot, vga_x, vga_y, erase
  );

  modport slave (
    output dude_x, dude_y, collide_valid, collide,
    input  startgame, upd_en, plot, vga_x, vga_y, erase
  );

endinterface

// File: rtl/sprite_sweep.sv
// Row-major pixel sweep over the sprite box at a latched position.
// Ports: clk, resetn, i_start (level, sweep runs while high),
// i_lat_x/i_lat_y (top-left), o_vga_x/o_vga_y/o_plot (registered),
// o_done (high on the cycle the last pixel is issued).
module sprite_sweep
  import josh_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_start,
  input  logic [7:0] i_lat_x,
  input  logic [6:0] i_lat_y,
  output logic [7:0] o_vga_x,
  output logic [6:0] o_vga_y,
  output logic       o_plot,
  output logic       o_done
);

  logic [7:0] r_px;
  logic [6:0] r_py;
  logic [7:0] r_vx;
  logic [6:0] r_vy;
  logic       r_plot;

  logic [8:0] w_sx;
  logic [7:0] w_sy;
  logic       w_last_x;
  logic       w_last_y;
  logic       w_on;

  assign w_last_x = (r_px == 8'(SPRITE_W - 1));
  assign w_last_y = (r_py == 7'(SPRITE_H - 1));

  assign w_sx = {1'b0, i_lat_x} + {1'b0, r_px};
  assign w_sy = {1'b0, i_lat_y} + {1'b0, r_py};
  assign w_on = on_screen(w_sx, w_sy);

  assign o_done = i_start && w_last_x && w_last_y;

  // Counters sit at 0 while idle so every sweep starts
  // at the top-left pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_px   <= '0;
      r_py   <= '0;
      r_vx   <= '0;
      r_vy   <= '0;
      r_plot <= 1'b0;
    end else if (i_start) begin
      r_vx   <= w_sx[7:0];
      r_vy   <= w_sy[6:0];
      r_plot <= w_on;
      if (w_last_x) begin
        r_px <= '0;
        r_py <= w_last_y ? '0 : r_py + 7'd1;
      end else begin
        r_px <= r_px + 8'd1;
      end
    end else begin
      r_px   <= '0;
      r_py   <= '0;
      r_vx   <= '0;
      r_vy   <= '0;
      r_plot <= 1'b0;
    end
  end

  assign o_vga_x = r_vx;
  assign o_vga_y = r_vy;
  assign o_plot  = r_plot;

endmodule

// File: rtl/game_sequencer.sv
// Frame-level controller for the jump game: menu/game FSM, frame
// tick, erase/update/verdict/redraw sequencing and survival score.
// Ports: clk, resetn (async, active low), go (level start request),
// bus (datapath inputs, upd_en/startgame, VGA plot outputs),
// game_over (OVER state), score (frames survived, saturating).
module game_sequencer
  import josh_pkg::*;
#(
  parameter int FRAME_DIV = 833333,
  parameter int SPRITE_W  = 4,
  parameter int SPRITE_H  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  game_sequencer_if.master bus,
  output logic             game_over,
  output logic [7:0]       score
);

  localparam int FW =
    (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FRAME_DIV - 1);

  state_t        r_state;
  state_t        w_next;
  logic [FW-1:0] r_fcnt;
  logic          r_pending;
  logic          r_erase;
  logic [7:0]    r_score;
  logic [7:0]    r_lat_x;
  logic [6:0]    r_lat_y;

  logic          w_run;
  logic          w_sweep;
  logic          w_tick;
  logic          w_done;
  logic          w_start;
  logic          w_survive;
  logic          w_load;
  logic [7:0]    w_vx;
  logic [6:0]    w_vy;
  logic          w_plot;

  assign w_run = r_state inside
    {S_DRAW, S_WAIT, S_ERASE, S_UPDATE, S_CHECK};
  assign w_sweep = r_state inside {S_DRAW, S_ERASE};
  assign w_tick  = w_run && (r_fcnt == F_LAST);

  assign w_start   = (r_state == S_MENU_WAIT) && !go;
  assign w_survive = (r_state == S_CHECK)
                   && bus.collide_valid && !bus.collide;
  assign w_load    = w_start || w_survive;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_MENU;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MENU: begin
        if (go) w_next = S_MENU_WAIT;
      end
      S_MENU_WAIT: begin
        if (!go) w_next = S_DRAW;
      end
      S_DRAW: begin
        if (w_done) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_tick || r_pending) w_next = S_ERASE;
      end
      S_ERASE: begin
        if (w_done) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        w_next = S_CHECK;
      end
      S_CHECK: begin
        if (bus.collide_valid)
          w_next = bus.collide ? S_OVER : S_DRAW;
      end
      S_OVER: begin
        if (go) w_next = S_MENU_WAIT;
      end
      default: begin
        w_next = S_MENU;
      end
    endcase
  end

  // Ticks only count while a game runs; a tick that lands
  // outside WAIT is remembered once, a second one is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fcnt    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (!w_run || w_tick) begin
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
      if (!w_run || r_state == S_WAIT) begin
        r_pending <= 1'b0;
      end else if (w_tick) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_score <= '0;
      r_lat_x <= '0;
      r_lat_y <= '0;
      r_erase <= 1'b0;
    end else begin
      if (w_start) begin
        r_score <= '0;
      end else if (w_survive && r_score != 8'hFF) begin
        r_score <= r_score + 8'd1;
      end
      if (w_load) begin
        r_lat_x <= bus.dude_x;
        r_lat_y <= bus.dude_y;
      end
      // Registered alongside the sweep outputs so it lines
      // up with the erase pixels.
      r_erase <= (r_state == S_ERASE);
    end
  end

  sprite_sweep #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_sweep (
    .clk     (clk),
    .resetn  (resetn),
    .i_start (w_sweep),
    .i_lat_x (r_lat_x),
    .i_lat_y (r_lat_y),
    .o_vga_x (w_vx),
    .o_vga_y (w_vy),
    .o_plot  (w_plot),
    .o_done  (w_done)
  );

  assign bus.startgame = w_run;
  assign bus.upd_en    = (r_state == S_UPDATE);
  assign bus.plot      = w_plot;
  assign bus.vga_x     = w_vx;
  assign bus.vga_y     = w_vy;
  assign bus.erase     = r_erase;
  assign game_over     = (r_state == S_OVER);
  assign score         = r_score;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with a frame-schedule model.
// The bench plays the datapath role (positions, verdicts).
module tb_game_sequencer;

  localparam int FD = 100;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int NP = SW * SH;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       game_over;
  logic [7:0] score;

  game_sequencer_if bus();

  game_sequencer #(
    .FRAME_DIV (FD),
    .SPRITE_W  (SW),
    .SPRITE_H  (SH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .bus       (bus),
    .game_over (game_over),
    .score     (score)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int D, G0, C, nfr, lx, ly;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Ticks fall on game cycles FD-1, 2*FD-1, ...
  function automatic int first_tick_ge(input int a);
    return ((a + FD) / FD) * FD - 1;
  endfunction

  function automatic logic [16:0] pix(input int x, input int y,
                                      input int i, input bit er);
    int sx, sy;
    logic [7:0] vx;
    logic [6:0] vy;
    bit on;
    sx = x + i % SW;
    sy = y + i / SW;
    on = (sx < 160) && (sy < 120);
    vx = 8'(sx % 256);
    vy = 7'(sy % 128);
    return {vx, vy, on, er};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.vga_x, bus.vga_y, bus.plot, bus.erase};
  endfunction

  task automatic idle_to(input int t);
    while (cyc < t) begin
      step();
      chk("idle", 32'({bus.plot, bus.upd_en}), 32'd0);
    end
  endtask

  task automatic sweep(input bit er, input bit junk);
    for (int i = 0; i < NP; i++) begin
      step();
      chk(er ? "erase_pix" : "draw_pix",
          32'(obs()), 32'(pix(lx, ly, i, er)));
      chk("upd_en", 32'(bus.upd_en), 32'(er && i == NP - 1));
      if (!er && i == 0) begin
        chk("score", 32'(score), 32'(sat(nfr)));
        chk("run", 32'({bus.startgame, game_over}), 32'd2);
      end
      if (junk && !er && i == 5) begin
        bus.dude_x = 8'($urandom_range(0, 255));
        bus.dude_y = 7'($urandom_range(0, 127));
      end
    end
  endtask

  task automatic start_game(input int x, input int y);
    bus.dude_x = 8'(x);
    bus.dude_y = 7'(y);
    go = 1'b1;
    repeat (5) begin
      step();
      chk("menu_quiet",
          32'({bus.plot, bus.startgame, bus.upd_en}), 32'd0);
    end
    go = 1'b0;
    D = cyc + 1;
    G0 = D;
    C = -1;
    nfr = 0;
    lx = x;
    ly = y;
  endtask

  task automatic run_frame(input int nx, input int ny,
                           input int dly, input bit hit,
                           input bit junk);
    int W, E, U, T;
    idle_to(D);
    sweep(1'b0, junk);
    W = D + NP - G0;
    if (first_tick_ge(C + 1) <= W - 1) begin
      E = W + 1;
      C = W;
    end else begin
      T = first_tick_ge(W);
      E = T + 1;
      C = T;
    end
    if (junk && E - W >= 4) begin
      idle_to(G0 + W + 2);
      bus.collide_valid = 1'b1;
      bus.collide = 1'b1;
      idle_to(G0 + W + 3);
      bus.collide_valid = 1'b0;
      bus.collide = 1'b0;
    end
    idle_to(G0 + E);
    sweep(1'b1, 1'b0);
    U = E + NP;
    idle_to(G0 + U + 1);
    bus.dude_x = 8'(nx);
    bus.dude_y = 7'(ny);
    idle_to(G0 + U + dly);
    bus.collide_valid = 1'b1;
    bus.collide = hit;
    idle_to(G0 + U + dly + 1);
    bus.collide_valid = 1'b0;
    bus.collide = 1'b0;
    if (hit) begin
      chk("over", 32'({game_over, bus.startgame}), 32'd2);
      chk("over_score", 32'(score), 32'(sat(nfr)));
    end else begin
      nfr++;
      lx = nx;
      ly = ny;
      D = cyc;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.dude_x = '0;
    bus.dude_y = '0;
    bus.collide_valid = 1'b0;
    bus.collide = 1'b0;

    step();
    chk("rst_plot", 32'(bus.plot), 32'd0);
    chk("rst_vga", 32'({bus.vga_x, bus.vga_y}), 32'd0);
    chk("rst_ctl", 32'({bus.startgame, bus.upd_en,
                        bus.erase, game_over}), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    resetn = 1'b1;
    repeat (3) begin
      step();
      chk("menu_idle", 32'({bus.plot, bus.startgame}), 32'd0);
    end

    start_game(10, 20);
    run_frame(10, 22, 3, 1'b0, 1'b0);
    run_frame(158, 118, 2, 1'b0, 1'b1);
    run_frame(50, 60, 5, 1'b0, 1'b1);
    run_frame(0, 0, 150, 1'b0, 1'b0);
    run_frame(70, 80, 4, 1'b0, 1'b0);
    run_frame(20, 30, 2, 1'b1, 1'b0);
    repeat (20) begin
      step();
      chk("over_hold", 32'({game_over, bus.startgame,
                            bus.plot}), 32'd4);
      chk("over_score_hold", 32'(score), 32'd5);
    end

    start_game(30, 40);
    run_frame(31, 41, 1, 1'b0, 1'b1);
    run_frame(32, 42, 6, 1'b0, 1'b0);
    idle_to(D);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("pre_rst_pix", 32'(obs()), 32'(pix(lx, ly, i, 1'b0)));
    end
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", 32'(bus.plot), 32'd0);
    chk("mid_rst_vga", 32'({bus.vga_x, bus.vga_y}), 32'd0);
    chk("mid_rst_score", 32'(score), 32'd0);
    chk("mid_rst_ctl", 32'({bus.startgame, bus.upd_en,
                            bus.erase, game_over}), 32'd0);
    step();
    step();
    resetn = 1'b1;
    repeat (250) begin
      step();
      chk("post_rst_quiet",
          32'({bus.plot, bus.upd_en, bus.startgame}), 32'd0);
    end

    start_game($urandom_range(0, 150), $urandom_range(0, 110));
    for (int f = 0; f < 301; f++) begin
      int nx, ny, dl;
      nx = $urandom_range(0, 170);
      ny = $urandom_range(0, 125);
      if ($urandom_range(0, 7) == 0)
        dl = $urandom_range(60, 220);
      else
        dl = $urandom_range(1, 8);
      run_frame(nx, ny, dl, 1'b0, 1'($urandom_range(0, 1)));
    end
    chk("score_sat", 32'(score), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
